// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : scan_pkg
//  Description : Shared types and constants for the display scan controller
//                (state encoding, digit geometry, digit extraction helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package scan_pkg;

  // Eight digits of four bits each
  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned SEL_W      = 3;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned WORD_W     = NUM_DIGITS * NIB_W;

  // Last digit index; leaving it completes a frame
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_ON    = 2'd2
  } scan_state_e;

  // Returns digit idx of a packed display word (digit k = bits [4k+3:4k])
  function automatic logic [NIB_W-1:0] digit_of(
    input logic [WORD_W-1:0] word,
    input logic [SEL_W-1:0]  idx
  );
    return word[NIB_W*int'(idx) +: NIB_W];
  endfunction

endpackage : scan_pkg
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Free-running prescaler. Produces a one-cycle tick every DIV
//                enabled clocks; counter is held at zero while disabled so the
//                first tick after enabling always arrives DIV cycles later.
//  Ports       : clk  - system clock
//                rst  - synchronous active-high reset
//                en   - count enable
//                tick - high in the cycle the counter sits at DIV-1 (and en=1)
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
  parameter int unsigned DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned     CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_last;

  always_comb begin
    at_last = (cnt_q == CNT_LAST);
    cnt_d   = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (at_last) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign tick = en && at_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : tick_gen
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_ctrl
//  Description : Time-multiplexed 8-digit display scan controller. Steps a
//                digit index through BLANK/ON phases timed in prescaler ticks,
//                drives a 3-to-8 enable decoder (sel_o/en_o) and the matching
//                digit value (nibble_o). The display word is double-buffered:
//                loads land in a pending buffer and are promoted to the active
//                buffer at the 7->0 wrap, or immediately while idle.
//  Ports       : clk, rst     - clock, synchronous active-high reset
//                run          - scanning enable
//                digits_in    - eight 4-bit digits, digit k at [4k+3:4k]
//                load         - 1-cycle strobe capturing digits_in
//                digit_mask   - per-digit lit enable, sampled live
//                sel_o        - digit index to the decoder
//                en_o         - decoder enable
//                nibble_o     - value of digit sel_o
//                frame_done   - 1-cycle pulse on the 7->0 wrap
//                load_ack     - 1-cycle pulse when the active buffer updates
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned DIV         = 1000,
  parameter int unsigned ON_TICKS    = 4,
  parameter int unsigned BLANK_TICKS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [WORD_W-1:0]     digits_in,
  input  logic                  load,
  input  logic [NUM_DIGITS-1:0] digit_mask,
  output logic [SEL_W-1:0]      sel_o,
  output logic                  en_o,
  output logic [NIB_W-1:0]      nibble_o,
  output logic                  frame_done,
  output logic                  load_ack
);

  // Phase counter is shared by BLANK and ON, so size it for the longer one
  localparam int unsigned PH_MAX = (ON_TICKS > BLANK_TICKS) ? ON_TICKS : BLANK_TICKS;
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [PH_W-1:0] ON_LAST    = PH_W'(ON_TICKS - 1);
  localparam logic [PH_W-1:0] BLANK_LAST = PH_W'(BLANK_TICKS - 1);

  // --------------------------------------------------------------------------
  // Prescaler
  // --------------------------------------------------------------------------
  logic tick;

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (run),
    .tick (tick)
  );

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  scan_state_e      state_q,  state_d;
  logic [PH_W-1:0]  phase_q,  phase_d;
  logic [SEL_W-1:0] sel_q,    sel_d;
  logic             en_q,     en_d;
  logic [NIB_W-1:0] nib_q,    nib_d;
  logic             fd_q,     fd_d;
  logic             ack_q,    ack_d;

  logic [WORD_W-1:0] active_q, active_d;
  logic [WORD_W-1:0] pend_q,   pend_d;
  logic              pflag_q,  pflag_d;

  logic frame_wrap;   // leaving digit 7 this cycle
  logic buf_update;   // active buffer takes a new word this cycle

  // --------------------------------------------------------------------------
  // Scan FSM: next state, phase, digit index
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    sel_d      = sel_q;
    frame_wrap = 1'b0;

    case (state_q)
      S_IDLE: begin
        sel_d   = '0;
        phase_d = '0;
        if (run) begin
          state_d = S_BLANK;
        end
      end

      S_BLANK: begin
        if (tick) begin
          if (phase_q == BLANK_LAST) begin
            state_d = S_ON;
            phase_d = '0;
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
      end

      S_ON: begin
        if (tick) begin
          if (phase_q == ON_LAST) begin
            // Digit switch always goes through BLANK, so en_o drops in the
            // same cycle sel_o changes and never overlaps it.
            state_d    = S_BLANK;
            phase_d    = '0;
            sel_d      = sel_q + SEL_W'(1);
            frame_wrap = (sel_q == SEL_LAST);
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        phase_d = '0;
        sel_d   = '0;
      end
    endcase

    // Dropping run abandons the scan from any state
    if (!run) begin
      state_d    = S_IDLE;
      phase_d    = '0;
      sel_d      = '0;
      frame_wrap = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Double buffer: pending capture and promotion to active
  // --------------------------------------------------------------------------
  always_comb begin
    pend_d     = pend_q;
    pflag_d    = pflag_q;
    active_d   = active_q;
    buf_update = 1'b0;

    if (load) begin
      pend_d  = digits_in;
      pflag_d = 1'b1;
    end

    // Promotion happens at the frame wrap, or right away while idle. A load
    // in the promotion cycle itself bypasses the pending buffer.
    if ((state_q == S_IDLE || frame_wrap) && (load || pflag_q)) begin
      active_d   = load ? digits_in : pend_q;
      pflag_d    = 1'b0;
      buf_update = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs, all computed from next-state values so sel_o,
  // nibble_o and en_o always change together.
  // --------------------------------------------------------------------------
  always_comb begin
    en_d  = (state_d == S_ON) && digit_mask[sel_d];
    nib_d = digit_of(active_d, sel_d);
    fd_d  = frame_wrap;
    ack_d = buf_update;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      phase_q  <= '0;
      sel_q    <= '0;
      en_q     <= 1'b0;
      nib_q    <= '0;
      fd_q     <= 1'b0;
      ack_q    <= 1'b0;
      active_q <= '0;
      pend_q   <= '0;
      pflag_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      sel_q    <= sel_d;
      en_q     <= en_d;
      nib_q    <= nib_d;
      fd_q     <= fd_d;
      ack_q    <= ack_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      pflag_q  <= pflag_d;
    end
  end

  assign sel_o      = sel_q;
  assign en_o       = en_q;
  assign nibble_o   = nib_q;
  assign frame_done = fd_q;
  assign load_ack   = ack_q;

endmodule : seg_scan_ctrl
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_ctrl
//  Description : Self-checking bench for seg_scan_ctrl. The reference model
//                derives scan position arithmetically from the number of
//                cycles since scanning started and applies the load/promote
//                rules to a pair of plain buffer variables.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

  localparam int DIV         = 2;
  localparam int ON_TICKS    = 3;
  localparam int BLANK_TICKS = 1;
  localparam int CPD         = DIV * (ON_TICKS + BLANK_TICKS); // cycles per digit
  localparam int BLANK_CYC   = DIV * BLANK_TICKS;              // dark cycles per digit
  localparam int FRAME       = 8 * CPD;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [31:0] digits_in;
  logic        load;
  logic [7:0]  digit_mask;
  logic [2:0]  sel_o;
  logic        en_o;
  logic [3:0]  nibble_o;
  logic        frame_done;
  logic        load_ack;

  seg_scan_ctrl #(
    .DIV         (DIV),
    .ON_TICKS    (ON_TICKS),
    .BLANK_TICKS (BLANK_TICKS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .digits_in  (digits_in),
    .load       (load),
    .digit_mask (digit_mask),
    .sel_o      (sel_o),
    .en_o       (en_o),
    .nibble_o   (nibble_o),
    .frame_done (frame_done),
    .load_ack   (load_ack)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model state ----------------
  bit          m_idle   = 1'b1;
  int          m_t      = 0;     // cycles since the idle cycle that started the scan
  logic [31:0] m_active = '0;
  logic [31:0] m_pend   = '0;
  bit          m_flag   = 1'b0;
  logic [2:0]  e_sel    = '0;
  logic        e_en     = 1'b0;
  logic [3:0]  e_nib    = '0;
  logic        e_fd     = 1'b0;
  logic        e_ack    = 1'b0;

  function automatic logic [9:0] dut_vec();
    return {sel_o, en_o, nibble_o, frame_done, load_ack};
  endfunction

  function automatic logic [9:0] exp_vec();
    return {e_sel, e_en, e_nib, e_fd, e_ack};
  endfunction

  // Advance one clock and update the model from the inputs seen at that edge
  task automatic step();
    bit prev_idle;
    bit wrap;
    @(posedge clk);
    #1;
    if (rst) begin
      m_idle = 1'b1; m_t = 0; m_active = '0; m_pend = '0; m_flag = 1'b0;
      e_sel = '0; e_en = 1'b0; e_nib = '0; e_fd = 1'b0; e_ack = 1'b0;
    end else begin
      prev_idle = m_idle;
      wrap      = 1'b0;
      if (!run) begin
        m_idle = 1'b1; m_t = 0;
        e_sel  = '0;   e_en = 1'b0;
      end else begin
        m_t    = prev_idle ? 1 : m_t + 1;
        m_idle = 1'b0;
        e_sel  = 3'((m_t / CPD) % 8);
        e_en   = ((m_t % CPD) >= BLANK_CYC) && digit_mask[e_sel];
        wrap   = (m_t % FRAME) == 0;
      end
      e_fd  = wrap;
      e_ack = 1'b0;
      if ((prev_idle || wrap) && (load || m_flag)) begin
        m_active = load ? digits_in : m_pend;
        m_flag   = 1'b0;
        e_ack    = 1'b1;
      end else if (load) begin
        m_pend = digits_in;
        m_flag = 1'b1;
      end
      if (load && e_ack) m_pend = digits_in;
      e_nib = m_active[4*int'(e_sel) +: 4];
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; run = 1'b0; load = 1'b0; digits_in = '0; digit_mask = 8'hFF;
    step(); step();
    checks++;
    if (dut_vec() !== 10'b0) begin
      failures++; $display("FAIL reset_outputs got=%h want=000", dut_vec());
    end
    rst = 1'b0;
    step();
    checks++;
    if (dut_vec() !== exp_vec()) begin
      failures++; $display("FAIL reset_idle got=%h want=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_idle_load();
    digits_in = 32'h76543210; load = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if (load_ack !== 1'b1 || en_o !== 1'b0 || sel_o !== 3'd0) begin
      failures++; $display("FAIL idle_load_ack ack=%b en=%b sel=%0d want ack=1 en=0 sel=0", load_ack, en_o, sel_o);
    end
    step();
    checks++;
    if (dut_vec() !== exp_vec() || load_ack !== 1'b0) begin
      failures++; $display("FAIL idle_load_after got=%h want=%h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_scan();
    int fd_cnt = 0;
    int en_cnt = 0;
    digit_mask = 8'hFF; run = 1'b1;
    for (int i = 1; i <= 2*FRAME + 4; i++) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL scan_model i=%0d got=%h want=%h", i, dut_vec(), exp_vec());
      end
      if (en_o && nibble_o !== {1'b0, sel_o}) begin
        failures++; $display("FAIL scan_nibble sel=%0d nib=%h want=%h", sel_o, nibble_o, sel_o);
      end
      if (frame_done) begin
        fd_cnt++;
        if (sel_o !== 3'd0) begin
          failures++; $display("FAIL scan_fd_sel sel=%0d want=0", sel_o);
        end
      end
      if (i <= FRAME && en_o) en_cnt++;
    end
    checks++;
    if (fd_cnt != 2) begin
      failures++; $display("FAIL scan_fd_count got=%0d want=2", fd_cnt);
    end
    checks++;
    if (en_cnt != 8 * DIV * ON_TICKS) begin
      failures++; $display("FAIL scan_en_count got=%0d want=%0d", en_cnt, 8 * DIV * ON_TICKS);
    end
  endtask

  task automatic test_midframe_load();
    bit hit = 1'b0;
    for (int i = 0; i < FRAME + CPD && !hit; i++) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL mid_seek got=%h want=%h", dut_vec(), exp_vec());
      end
      hit = (sel_o == 3'd2);
    end
    checks++;
    if (!hit) begin
      failures++; $display("FAIL mid_seek_timeout sel=%0d want=2", sel_o);
    end
    digits_in = 32'hFEDCBA98; load = 1'b1;
    step();
    load = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < FRAME && !hit; i++) begin
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL mid_model got=%h want=%h", dut_vec(), exp_vec());
      end
      hit = frame_done;
      if (!hit) begin
        if ((en_o && nibble_o !== {1'b0, sel_o}) || load_ack) begin
          failures++; $display("FAIL mid_old_word sel=%0d nib=%h ack=%b want nib=%h ack=0", sel_o, nibble_o, load_ack, sel_o);
        end
        step();
      end
    end
    checks++;
    if (!hit || load_ack !== 1'b1 || nibble_o !== 4'h8) begin
      failures++; $display("FAIL mid_wrap fd=%b ack=%b nib=%h want fd=1 ack=1 nib=8", frame_done, load_ack, nibble_o);
    end
  endtask

  task automatic test_double_load();
    int ack_cnt = 0;
    bit hit = 1'b0;
    digits_in = 32'h11111111; load = 1'b1;
    step();
    load = 1'b0;
    if (load_ack) ack_cnt++;
    for (int i = 0; i < 10; i++) begin
      step();
      if (load_ack) ack_cnt++;
    end
    digits_in = 32'h22222222; load = 1'b1;
    step();
    load = 1'b0;
    if (load_ack) ack_cnt++;
    for (int i = 0; i < FRAME && !hit; i++) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL dbl_model got=%h want=%h", dut_vec(), exp_vec());
      end
      if (load_ack) ack_cnt++;
      hit = frame_done;
    end
    checks++;
    if (!hit || nibble_o !== 4'h2) begin
      failures++; $display("FAIL dbl_wrap fd=%b nib=%h want fd=1 nib=2", frame_done, nibble_o);
    end
    for (int i = 0; i < FRAME - 1; i++) begin
      step();
      if (load_ack) ack_cnt++;
      checks++;
      if (nibble_o !== 4'h2) begin
        failures++; $display("FAIL dbl_nibble sel=%0d nib=%h want=2", sel_o, nibble_o);
      end
    end
    checks++;
    if (ack_cnt != 1) begin
      failures++; $display("FAIL dbl_ack_count got=%0d want=1", ack_cnt);
    end
  endtask

  task automatic test_mask();
    logic [2:0] prev_sel;
    digit_mask = 8'b1010_1010;
    prev_sel   = sel_o;
    for (int i = 0; i < FRAME + 8; i++) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL mask_model got=%h want=%h", dut_vec(), exp_vec());
      end
      if (en_o && (!sel_o[0] || sel_o !== prev_sel)) begin
        failures++; $display("FAIL mask_en sel=%0d prev=%0d en=%b want en=0", sel_o, prev_sel, en_o);
      end
      prev_sel = sel_o;
    end
  endtask

  task automatic test_run_drop();
    bit hit = 1'b0;
    logic [31:0] word;
    digit_mask = 8'hFF;
    for (int i = 0; i < FRAME + CPD && !hit; i++) begin
      step();
      hit = (sel_o == 3'd5) && en_o;
    end
    checks++;
    if (!hit) begin
      failures++; $display("FAIL drop_seek_timeout sel=%0d en=%b want sel=5 en=1", sel_o, en_o);
    end
    word = $urandom;
    digits_in = word; load = 1'b1; run = 1'b0;
    step();
    load = 1'b0;
    checks++;
    if (en_o !== 1'b0 || sel_o !== 3'd0 || frame_done !== 1'b0 || load_ack !== 1'b0) begin
      failures++; $display("FAIL drop_idle en=%b sel=%0d fd=%b ack=%b want 0 0 0 0", en_o, sel_o, frame_done, load_ack);
    end
    step();
    checks++;
    if (load_ack !== 1'b1 || nibble_o !== word[3:0]) begin
      failures++; $display("FAIL drop_pending ack=%b nib=%h want ack=1 nib=%h", load_ack, nibble_o, word[3:0]);
    end
    step();
    run = 1'b1;
    step();
    checks++;
    if (en_o !== 1'b0 || sel_o !== 3'd0) begin
      failures++; $display("FAIL drop_restart en=%b sel=%0d want en=0 sel=0", en_o, sel_o);
    end
    for (int i = 0; i < 2*CPD; i++) begin
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL drop_model got=%h want=%h", dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_rst_mid();
    bit hit = 1'b0;
    int ack_cnt = 0;
    for (int i = 0; i < FRAME + CPD && !hit; i++) begin
      step();
      hit = (sel_o == 3'd3);
    end
    digits_in = $urandom; load = 1'b1;
    step();
    load = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < FRAME + CPD && !hit; i++) begin
      step();
      hit = (sel_o == 3'd5) && en_o;
    end
    checks++;
    if (!hit) begin
      failures++; $display("FAIL rst_seek_timeout sel=%0d want=5", sel_o);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (dut_vec() !== 10'b0) begin
      failures++; $display("FAIL rst_mid_outputs got=%h want=000", dut_vec());
    end
    for (int i = 0; i < FRAME + 4; i++) begin
      step();
      if (load_ack) ack_cnt++;
      checks++;
      if (dut_vec() !== exp_vec() || nibble_o !== 4'h0) begin
        failures++; $display("FAIL rst_mid_model got=%h want=%h", dut_vec(), exp_vec());
      end
    end
    checks++;
    if (ack_cnt != 0) begin
      failures++; $display("FAIL rst_pending_cleared acks=%0d want=0", ack_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      run  = ($urandom_range(0, 99) != 0);
      load = ($urandom_range(0, 24) == 0);
      rst  = ($urandom_range(0, 599) == 0);
      digits_in = $urandom;
      if ($urandom_range(0, 15) == 0) digit_mask = 8'($urandom);
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++; $display("FAIL random_model i=%0d got=%h want=%h", i, dut_vec(), exp_vec());
      end
    end
    rst = 1'b0; load = 1'b0; run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_load();
    test_scan();
    test_midframe_load();
    test_double_load();
    test_mask();
    test_run_drop();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_seg_scan_ctrl
`default_nettype wire
